// File: rtl/usb_pkt_dispatch_pkg.sv
// Shared constants and state encodings for the USB packet cache / channel dispatcher.
package usb_pkt_pkg;

   localparam logic [7:0] HDR_MARK        = 8'hFF;
   localparam int         HDR_MARK_HI_LSB = 24;
   localparam int         HDR_CH_LSB      = 16;
   localparam int         HDR_NB_LSB      = 8;
   localparam int         HDR_MARK_LO_LSB = 0;

   localparam int ERR_LONG    = 0;
   localparam int ERR_SHORT   = 1;
   localparam int ERR_BAD_HDR = 2;

   typedef enum logic [1:0] {S_HDR, S_PAY, S_DROP} in_state_t;
   typedef enum logic       {D_IDLE, D_RUN}        disp_state_t;

endpackage

// File: rtl/usb_pkt_dispatch_if.sv
// Input word stream plus channel-RAM write port and status pulses of the dispatcher.
interface usb_pkt_dispatch_if #(
   parameter int DATA_W = 32,
   parameter int N_CH   = 16,
   parameter int BURST  = 32
);
   logic                     in_valid;
   logic                     in_ready;
   logic [DATA_W-1:0]        in_data;
   logic                     in_last;
   logic [N_CH-1:0]          ch_wren;
   logic [$clog2(BURST)-1:0] ch_addr;
   logic [DATA_W-1:0]        ch_data;
   logic                     busy;
   logic                     done;
   logic [2:0]               err;

   modport master (
      output in_valid, in_data, in_last,
      input  in_ready, ch_wren, ch_addr, ch_data, busy, done, err
   );

   modport slave (
      input  in_valid, in_data, in_last,
      output in_ready, ch_wren, ch_addr, ch_data, busy, done, err
   );
endinterface

// File: rtl/usb_pkt_dispatch_fifo.sv
// pkt_fifo: single-clock payload FIFO with registered read data and an occupancy count.
module pkt_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [DATA_W-1:0]          din,
   input  logic                       pop,
   output logic [DATA_W-1:0]          dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // dout is cleared by reset so the channel write-data output starts at zero
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            dout   <= mem[rd_ptr];
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/usb_pkt_dispatch.sv
// Packet cache and round-robin channel dispatcher; optional statistics under USB_PKT_STATS_EN.
module usb_pkt_dispatch
   import usb_pkt_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int N_CH   = 16,
   parameter int BURST  = 32
) (
   input  logic              wrclock,
   input  logic              rst,
   usb_pkt_dispatch_if.slave bus
`ifdef USB_PKT_STATS_EN
   ,
   output logic [15:0]       pkt_cnt,
   output logic [15:0]       drop_cnt
`endif
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int AW    = $clog2(BURST);
   localparam int LEN_W = AW + 1;
   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST);
   localparam logic [15:0]      BURST_16  = 16'(BURST);
   localparam logic [8:0]       N_CH_9    = 9'(N_CH);

   in_state_t         s_state;
   disp_state_t       d_state;
   logic [15:0]       pay_cnt;
   logic [15:0]       pay_exp;
   logic [15:0]       pay_next;
   logic              in_done;
   logic [2:0]        err_p1;
   logic [7:0]        bursts_left;
   logic [CH_W-1:0]   ch;
   logic              in_burst;
   logic              bfinal;
   logic [AW-1:0]     bcnt;
   logic [LEN_W-1:0]  blen;
   logic              busy_p1;
   logic              vld_p1;
   logic [N_CH-1:0]   wren_p1;
   logic [AW-1:0]     addr_p1;
   logic              done_p1;

   logic              push;
   logic              pop;
   logic [DATA_W-1:0] fifo_dout;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full;
   logic              fifo_empty;

   logic              in_ready_c;
   logic              accept;
   logic              hdr_ok;
   logic              hdr_start;
   logic [7:0]        hdr_ch;
   logic [7:0]        hdr_nb;
   logic              burst_start;
   logic              burst_end;
   logic [AW-1:0]     addr_cur;
   logic [LEN_W-1:0]  len_cur;
   logic              final_cur;

   function automatic logic [N_CH-1:0] ch_onehot(input logic [CH_W-1:0] c);
      return {{(N_CH-1){1'b0}}, 1'b1} << c;
   endfunction

   function automatic logic [CH_W-1:0] ch_next(input logic [CH_W-1:0] c);
      return (32'(c) + 1 == N_CH) ? '0 : c + CH_W'(1);
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   pkt_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (wrclock),
      .rst   (rst),
      .push  (push),
      .din   (bus.in_data),
      .pop   (pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      hdr_ch = bus.in_data[HDR_CH_LSB +: 8];
      hdr_nb = bus.in_data[HDR_NB_LSB +: 8];
      hdr_ok = (bus.in_data[HDR_MARK_HI_LSB +: 8] == HDR_MARK) &&
               (bus.in_data[HDR_MARK_LO_LSB +: 8] == HDR_MARK) &&
               (hdr_nb != 8'd0) && ({1'b0, hdr_ch} < N_CH_9);
      case (s_state)
         S_HDR:   in_ready_c = (d_state == D_IDLE);
         S_PAY:   in_ready_c = !fifo_full;
         default: in_ready_c = 1'b1;
      endcase
   end

   assign accept    = bus.in_valid && in_ready_c;
   assign push      = accept && (s_state == S_PAY);
   assign pay_next  = pay_cnt + 16'd1;
   assign hdr_start = accept && (s_state == S_HDR) && hdr_ok && !bus.in_last;

   // Input stage: header parse, payload counting, length errors
   always_ff @(posedge wrclock) begin
      if (rst) begin
         s_state <= S_HDR;
         pay_cnt <= '0;
         pay_exp <= '0;
         in_done <= 1'b0;
         err_p1  <= '0;
      end else begin
         err_p1 <= '0;
         if (accept) begin
            case (s_state)
               S_HDR: begin
                  if (!hdr_ok) begin
                     err_p1[ERR_BAD_HDR] <= 1'b1;
                     s_state <= bus.in_last ? S_HDR : S_DROP;
                  end else if (bus.in_last) begin
                     err_p1[ERR_SHORT] <= 1'b1;
                  end else begin
                     s_state <= S_PAY;
                     pay_cnt <= '0;
                     pay_exp <= 16'(hdr_nb) * BURST_16;
                     in_done <= 1'b0;
                  end
               end
               S_PAY: begin
                  pay_cnt <= pay_next;
                  if (pay_next == pay_exp) begin
                     in_done <= 1'b1;
                     if (bus.in_last) begin
                        s_state <= S_HDR;
                     end else begin
                        s_state <= S_DROP;
                        err_p1[ERR_LONG] <= 1'b1;
                     end
                  end else if (bus.in_last) begin
                     in_done <= 1'b1;
                     s_state <= S_HDR;
                     err_p1[ERR_SHORT] <= 1'b1;
                  end
               end
               default: begin
                  if (bus.in_last) s_state <= S_HDR;
               end
            endcase
         end
      end
   end

   // A burst only starts once all of its words are already in the FIFO
   always_comb begin
      burst_start = (d_state == D_RUN) && !in_burst &&
                    ((fifo_count >= BURST_CNT) || (in_done && !fifo_empty));
      pop         = burst_start || in_burst;
      addr_cur    = burst_start ? '0 : bcnt;
      len_cur     = blen;
      final_cur   = bfinal;
      if (burst_start) begin
         len_cur   = (fifo_count >= BURST_CNT) ? LEN_W'(BURST) : LEN_W'(fifo_count);
         final_cur = (bursts_left == 8'd1) || (in_done && (fifo_count <= BURST_CNT));
      end
      burst_end   = pop && ({1'b0, addr_cur} == len_cur - LEN_W'(1));
   end

   // Dispatch stage p1: FIFO read data, write enable and address line up here
   always_ff @(posedge wrclock) begin
      if (rst) begin
         d_state     <= D_IDLE;
         in_burst    <= 1'b0;
         bcnt        <= '0;
         blen        <= '0;
         bfinal      <= 1'b0;
         ch          <= '0;
         bursts_left <= '0;
         busy_p1     <= 1'b0;
         vld_p1      <= 1'b0;
         wren_p1     <= '0;
         addr_p1     <= '0;
         done_p1     <= 1'b0;
      end else begin
         vld_p1  <= pop;
         wren_p1 <= pop ? ch_onehot(ch) : '0;
         done_p1 <= 1'b0;
         if (pop) addr_p1 <= addr_cur;
         case (d_state)
            D_IDLE: begin
               if (hdr_start) begin
                  d_state     <= D_RUN;
                  ch          <= CH_W'(hdr_ch);
                  bursts_left <= hdr_nb;
               end
            end
            default: begin
               if (pop) begin
                  if (burst_end) begin
                     in_burst <= 1'b0;
                     if (final_cur) begin
                        d_state <= D_IDLE;
                        done_p1 <= 1'b1;
                     end else begin
                        ch          <= ch_next(ch);
                        bursts_left <= bursts_left - 8'd1;
                     end
                  end else begin
                     in_burst <= 1'b1;
                     bcnt     <= addr_cur + AW'(1);
                     blen     <= len_cur;
                     bfinal   <= final_cur;
                  end
               end
            end
         endcase
         if (hdr_start)    busy_p1 <= 1'b1;
         else if (done_p1) busy_p1 <= 1'b0;
      end
   end

   assign bus.in_ready = in_ready_c;
   assign bus.ch_wren  = vld_p1 ? wren_p1 : '0;
   assign bus.ch_addr  = addr_p1;
   assign bus.ch_data  = fifo_dout;
   assign bus.busy     = busy_p1;
   assign bus.done     = done_p1;
   assign bus.err      = err_p1;

`ifdef USB_PKT_STATS_EN
   always_ff @(posedge wrclock) begin
      if (rst) begin
         pkt_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         if (done_p1)         pkt_cnt  <= sat_inc(pkt_cnt);
         if (err_p1 != 3'b0)  drop_cnt <= sat_inc(drop_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_usb_pkt_dispatch.sv
// Directed bench for usb_pkt_dispatch: packet framing, channel rotation, errors, back-pressure, reset.
module tb_usb_pkt_dispatch;
   logic wrclock = 1'b0;
   logic rst     = 1'b1;
   always #5 wrclock = ~wrclock;

   usb_pkt_dispatch_if #(.DATA_W(32), .N_CH(16), .BURST(32)) bus ();

`ifdef USB_PKT_STATS_EN
   logic [15:0] pkt_cnt;
   logic [15:0] drop_cnt;
`endif

   usb_pkt_dispatch #(.DATA_W(32), .DEPTH(256), .N_CH(16), .BURST(32)) dut (
      .wrclock (wrclock),
      .rst     (rst),
      .bus     (bus)
`ifdef USB_PKT_STATS_EN
      ,
      .pkt_cnt (pkt_cnt),
      .drop_cnt(drop_cnt)
`endif
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   int          nwr;
   int          w_ch   [512];
   int          w_addr [512];
   logic [31:0] w_data [512];
   int          w_cyc  [512];
   int          done_cnt, done_wr, done_cyc;
   int          err_cnt, err_cyc;
   logic [2:0]  err_acc;
   int          oh_bad = 0;

   always @(posedge wrclock) cyc++;

   always @(negedge wrclock) begin
      int wch;
      wch = -1;
      if (bus.ch_wren != '0) begin
         for (int c = 0; c < 16; c++) if (bus.ch_wren[c]) wch = c;
         if ($countones(bus.ch_wren) != 1) oh_bad++;
         if (nwr < 512) begin
            w_ch[nwr]   = wch;
            w_addr[nwr] = int'(bus.ch_addr);
            w_data[nwr] = bus.ch_data;
            w_cyc[nwr]  = cyc;
         end
         nwr++;
      end
      if (bus.done) begin
         done_cnt++;
         done_wr  = nwr;
         done_cyc = cyc;
      end
      if (bus.err != 3'b000) begin
         err_acc |= bus.err;
         err_cnt++;
         err_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      nwr = 0; done_cnt = 0; done_wr = 0; done_cyc = 0;
      err_cnt = 0; err_cyc = 0; err_acc = 3'b000;
   endtask

   // Present one word from a negedge; returns the cycle in which it was presented with ready high
   task automatic send(input logic [31:0] d, input logic l, output int pc);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = l;
      while (bus.in_ready !== 1'b1 && n < 5000) begin
         @(negedge wrclock);
         n++;
      end
      pc = cyc;
      if (n >= 5000) chk("send_timeout", 32'd0, 32'd1);
      @(negedge wrclock);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic send_pkt(input logic [31:0] hdr, input int nwords, input int last_at,
                           input logic [31:0] base, output int pc32);
      int pc;
      pc32 = 0;
      send(hdr, 1'b0, pc);
      for (int i = 1; i <= nwords; i++) begin
         send(base + 32'(i - 1), (i == last_at), pc);
         if (i == 32) pc32 = pc;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.busy === 1'b1 && n < 3000) begin
         @(negedge wrclock);
         n++;
      end
      if (n >= 3000) chk("idle_timeout", 32'd0, 32'd1);
      repeat (3) @(negedge wrclock);
   endtask

   task automatic check_writes(input string tag, input int first, input int cnt,
                               input int ch, input logic [31:0] dbase);
      int bad;
      bad = 0;
      for (int k = 0; k < cnt; k++) begin
         if (w_ch[first+k] != ch || w_addr[first+k] != k || w_data[first+k] !== dbase + 32'(k))
            bad++;
      end
      chk(tag, 32'(bad), 32'd0);
   endtask

   initial begin
      int pc32, pc, n_after;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      clear_log();
      repeat (3) @(negedge wrclock);

      chk("rst_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_wren",  32'(bus.ch_wren),  32'd0);
      chk("rst_addr",  32'(bus.ch_addr),  32'd0);
      chk("rst_data",  bus.ch_data,       32'd0);
      chk("rst_busy",  32'(bus.busy),     32'd0);
      chk("rst_done",  32'(bus.done),     32'd0);
      chk("rst_err",   32'(bus.err),      32'd0);
      rst = 1'b0;
      @(negedge wrclock);

      // Two bursts starting at channel 3
      clear_log();
      send_pkt(32'hFF0302FF, 64, 64, 32'h1000_0000, pc32);
      wait_idle();
      chk("t1_nwr", 32'(nwr), 32'd64);
      check_writes("t1_ch3", 0, 32, 3, 32'h1000_0000);
      check_writes("t1_ch4", 32, 32, 4, 32'h1000_0020);
      chk("t1_done_cnt", 32'(done_cnt), 32'd1);
      chk("t1_done_on_last", 32'(done_wr), 32'd64);
      chk("t1_err", 32'(err_acc), 32'd0);
      chk("t1_first_wr_latency", 32'(w_cyc[0] - pc32), 32'd2);
      chk("t1_no_gap", 32'(w_cyc[63] - w_cyc[0]), 32'd63);

      // Wrap from channel 15 to channel 0
      clear_log();
      send_pkt(32'hFF0F02FF, 64, 64, 32'h2000_0000, pc32);
      wait_idle();
      chk("t2_nwr", 32'(nwr), 32'd64);
      check_writes("t2_ch15", 0, 32, 15, 32'h2000_0000);
      check_writes("t2_ch0", 32, 32, 0, 32'h2000_0020);
      chk("t2_done_cnt", 32'(done_cnt), 32'd1);

      // start_ch out of range: drop until in_last
      clear_log();
      send_pkt(32'hFF1001FF, 5, 5, 32'h3000_0000, pc32);
      wait_idle();
      chk("t3_err", 32'(err_acc), 32'b100);
      chk("t3_err_pulses", 32'(err_cnt), 32'd1);
      chk("t3_nwr", 32'(nwr), 32'd0);
      chk("t3_done_cnt", 32'(done_cnt), 32'd0);
      chk("t3_ready_after", 32'(bus.in_ready), 32'd1);

      // Short packet: 40 of 64 words
      clear_log();
      send_pkt(32'hFF0502FF, 40, 40, 32'h4000_0000, pc32);
      wait_idle();
      chk("t4_err", 32'(err_acc), 32'b010);
      chk("t4_nwr", 32'(nwr), 32'd40);
      check_writes("t4_ch5", 0, 32, 5, 32'h4000_0000);
      check_writes("t4_ch6", 32, 8, 6, 32'h4000_0020);
      chk("t4_done_cnt", 32'(done_cnt), 32'd1);
      chk("t4_done_on_last", 32'(done_wr), 32'd40);

      // Long packet: 40 words for a single burst
      clear_log();
      send_pkt(32'hFF0701FF, 40, 40, 32'h5000_0000, pc32);
      wait_idle();
      chk("t5_err", 32'(err_acc), 32'b001);
      chk("t5_err_pulses", 32'(err_cnt), 32'd1);
      chk("t5_err_after_w32", 32'(err_cyc - pc32), 32'd1);
      chk("t5_nwr", 32'(nwr), 32'd32);
      check_writes("t5_ch7", 0, 32, 7, 32'h5000_0000);
      chk("t5_done_cnt", 32'(done_cnt), 32'd1);

      // Header blocked while previous packet still dispatches, then reset mid-burst
      clear_log();
      send_pkt(32'hFF0102FF, 64, 64, 32'h6000_0000, pc32);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hFF0201FF;
      chk("t6_hdr_blocked", 32'(bus.in_ready), 32'd0);
      send(32'hFF0201FF, 1'b0, pc);
      chk("t6_hdr_at_done", 32'(pc), 32'(done_cyc));
      chk("t6_first_done", 32'(done_cnt), 32'd1);
      for (int i = 1; i <= 32; i++) send(32'h6100_0000 + 32'(i - 1), (i == 32), pc);
      repeat (4) @(negedge wrclock);
      rst = 1'b1;
      @(negedge wrclock);
      chk("t6_rst_wren", 32'(bus.ch_wren), 32'd0);
      chk("t6_rst_busy", 32'(bus.busy), 32'd0);
      chk("t6_rst_data", bus.ch_data, 32'd0);
      chk("t6_rst_ready", 32'(bus.in_ready), 32'd1);
      n_after = nwr;
      rst = 1'b0;
      repeat (40) @(negedge wrclock);
      chk("t6_no_wr_after_rst", 32'(nwr), 32'(n_after));
      chk("t6_burst_aborted", 32'(n_after < 96), 32'd1);

      // FIFO must be empty after reset: fresh packet sees only its own data
      clear_log();
      send_pkt(32'hFF0001FF, 32, 32, 32'h7000_0000, pc32);
      wait_idle();
      chk("t7_nwr", 32'(nwr), 32'd32);
      check_writes("t7_ch0", 0, 32, 0, 32'h7000_0000);
      chk("t7_done_cnt", 32'(done_cnt), 32'd1);
      chk("t7_err", 32'(err_acc), 32'd0);
      chk("onehot_wren", 32'(oh_bad), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
      $fatal(1, "bench timeout");
   end
endmodule

// File: doc/usb_pkt_dispatch.md
# usb_pkt_dispatch

Parametrised packet cache and channel dispatcher between the USB3 FIFO read path and the per-channel DA sample RAMs. Accepts a stream of DATA_W-bit words framed by a header word, buffers the payload in an internal FIFO, and writes it to N_CH channel RAMs in fixed BURST-word bursts, rotating across channels. It generalises the current 256-word cache with hard-coded 16-channel, 32-word write enables to arbitrary width, depth, channel count and burst length. It adds header validation, length checking and back-pressure.

## Interface
- DATA_W, 32, word width; must be at least 32.
- DEPTH, 256, payload FIFO depth in words; power of two, at least 2*BURST.
- N_CH, 16, number of channel RAMs; 2..256.
- BURST, 32, words per channel burst; power of two.
- wrclock  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid && in_ready.
- in_data  in  DATA_W  header or payload word.
- in_last  in  1  last word of the USB transfer; qualified by in_valid.
- ch_wren  out  N_CH  one-hot channel RAM write enable.
- ch_addr  out  $clog2(BURST)  word address within the burst.
- ch_data  out  DATA_W  write data.
- busy  out  1  a packet is being received or dispatched.
- done  out  1  one-cycle pulse when the last burst word of a packet is written.
- err  out  3  one-cycle pulse on error: {bad_hdr, short, long}.

## Operation
- Header word: in_data[31:24]==8'hFF and in_data[7:0]==8'hFF. Field start_ch=in_data[23:16]; field nburst=in_data[15:8].
- Header is invalid if the marker mismatches, nburst==0, or start_ch>=N_CH. An invalid header pulses err[2] and the FSM enters S_DROP.
- Expected payload length = nburst*BURST words. The counter is 16 bits wide.
- Input FSM:
  - S_HDR → S_PAY on a valid header, or → S_DROP on an invalid header.
  - S_PAY → S_HDR when the expected word count is reached and in_last is set on that word.
  - S_PAY → S_DROP when the expected count is reached without in_last. Pulse err[0]; later words are discarded.
  - S_PAY → S_HDR on in_last before the expected count. Pulse err[1] (short).
  - S_DROP → S_HDR on an accepted word carrying in_last. In_last on the header word itself is handled identically.
- in_ready:
  - 0 in S_HDR while the dispatcher is active: one packet in flight.
  - 0 in S_PAY when the FIFO is full.
  - 1 in S_DROP.
- Dispatcher FSM:
  - D_IDLE → D_RUN when the header is latched.
  - In D_RUN, a burst starts when the FIFO holds at least BURST words, or when input for the packet has ended and the FIFO is non-empty.
  - Each burst pops one word per cycle, with ch_addr counting 0..BURST-1.
  - After a full burst: ch ← (ch+1 == N_CH) ? 0 : ch+1, and the burst count decrements.
  - A short packet's final partial burst writes only the words received; the remaining bursts are skipped.
  - D_RUN → D_IDLE after the last word; done pulses with that last write.
- Once a burst has started it is never interrupted: the FIFO already holds all BURST words.
- Simultaneous FIFO push and pop: both take effect, and the count is unchanged.
- Reset values:
  - in_ready=1, ch_wren=0, ch_addr=0, ch_data=0, busy=0, done=0, err=0.
  - FIFO emptied; both FSMs in their idle states.
- Reset mid-burst aborts the burst immediately. No further ch_wren occurs.

## Timing
- FIFO read latency is 1 cycle. ch_wren/ch_addr/ch_data are registered and aligned in the same cycle.
- First ch_wren occurs 2 cycles after the BURST-th payload word is accepted.
- Sustained rate is one word per cycle in and out. There are no idle cycles between consecutive bursts of one packet when the FIFO is sufficiently filled.
- err and done are single-cycle pulses.
- busy rises the cycle after a header is accepted and falls the cycle after done.

## Configuration
- USB_PKT_STATS_EN defined:
  - Adds outputs pkt_cnt[15:0] (packets completed) and drop_cnt[15:0] (packets with any err bit).
  - Both are saturating counters, cleared by rst.
- USB_PKT_STATS_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Package usb_pkt_pkg holds:
  - HDR_MARK=8'hFF and the field bit positions.
  - Input FSM enum {S_HDR, S_PAY, S_DROP}.
  - Dispatcher enum {D_IDLE, D_RUN}.
  - err bit indices.
- Sub-module pkt_fifo: single-clock FIFO, DATA_W x DEPTH, registered read, with a count output.
- Top-level module contains the two FSMs and the channel rotation logic.

## Test plan
- Valid header 0xFF0302FF + 64 words, with in_last on word 64 → channel 3 gets 32 writes at addr 0..31, then channel 4 gets 32 writes; done pulses once; err=0.
- Header 0xFF0F02FF (N_CH=16) → bursts go to channel 15 then channel 0 (wrap-around).
- Header 0xFF1001FF (start_ch=16) → err=3'b100; the following words are discarded up to in_last; no ch_wren.
- nburst=2, in_last on word 40 → err=3'b010; 32 writes to start_ch, then 8 writes to start_ch+1 at addr 0..7; done pulses.
- nburst=1, 40 words sent → err=3'b001 after word 32; words 33..40 are accepted with no writes.
- Second header presented while the first packet is still dispatching → in_ready=0 until done. Assert rst during a burst → ch_wren=0 the next cycle, and outputs hold reset values.
